// File: rtl/kms_pkg.sv
// Shared encodings for the keyboard/mouse event scheduler: strobe types and FSM states.
package kms_pkg;

  localparam logic [1:0] KMS_MOUSE_X = 2'd0;
  localparam logic [1:0] KMS_MOUSE_Y = 2'd1;
  localparam logic [1:0] KMS_KEY     = 2'd2;
  localparam logic [1:0] KMS_OSD     = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } kms_state_t;

endpackage

// File: rtl/kms_fifo.sv
// Byte FIFO for queued keycodes; a pop frees the head slot for a push in the same cycle.
module kms_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == L_FULL);
  assign o_head    = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_data;
  end

endmodule

// File: rtl/kms_event_sched.sv
// Keyboard/mouse event scheduler: mouse delta counters plus queued, acknowledged key port.
// Build option KMS_OSD_QUEUE_EN adds the OSD queue and round-robin arbitration.
module kms_event_sched
  import kms_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ACK_TIMEOUT = 65535,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       kms_strobe,
  input  logic [1:0] kms_type,
  input  logic [7:0] kms_data,
  input  logic       mouse_idx,
  output logic [7:0] mouse0_x,
  output logic [7:0] mouse0_y,
  output logic [7:0] mouse0_w,
  output logic [7:0] mouse1_x,
  output logic [7:0] mouse1_y,
  output logic [7:0] mouse1_w,
  output logic       key_valid,
  output logic [7:0] key_data,
  output logic       key_osd,
  input  logic       key_ack,
  output logic       key_retry,
  output logic       key_lost,
  output logic       kbd_overflow,
  output logic       osd_overflow
);

  localparam logic [31:0] L_TMAX = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0] L_RMAX = 32'(MAX_RETRY);

  kms_state_t  r_state;
  logic [7:0]  r_m0x, r_m0y, r_m0w, r_m1x, r_m1y, r_m1w;
  logic [1:0]  r_yseen;
  logic        r_key_valid;
  logic [7:0]  r_key_data;
  logic        r_key_osd;
  logic        r_last_osd;
  logic [31:0] r_timer;
  logic [31:0] r_retry_cnt;
  logic        r_retry_p;
  logic        r_lost_p;
  logic        r_kbd_ovf;

  logic        w_push_kbd;
  logic        w_pop_kbd;
  logic [7:0]  w_kbd_head;
  logic        w_kbd_empty;
  logic        w_kbd_full;
  logic        w_pop_osd;
  logic [7:0]  w_osd_head;
  logic        w_osd_empty;
  logic        w_grant_osd;
  logic        w_any;

  assign w_push_kbd = kms_strobe & (kms_type == KMS_KEY);

  kms_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_kbd_fifo (
    .i_clk       (clk_sys),
    .i_rst       (reset),
    .i_push      (w_push_kbd),
    .i_push_data (kms_data),
    .i_pop       (w_pop_kbd),
    .o_head      (w_kbd_head),
    .o_empty     (w_kbd_empty),
    .o_full      (w_kbd_full)
  );

`ifdef KMS_OSD_QUEUE_EN
  logic w_push_osd;
  logic w_osd_full;
  logic r_osd_ovf;

  assign w_push_osd = kms_strobe & (kms_type == KMS_OSD);

  kms_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_osd_fifo (
    .i_clk       (clk_sys),
    .i_rst       (reset),
    .i_push      (w_push_osd),
    .i_push_data (kms_data),
    .i_pop       (w_pop_osd),
    .o_head      (w_osd_head),
    .o_empty     (w_osd_empty),
    .o_full      (w_osd_full)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_osd_ovf <= 1'b0;
    else       r_osd_ovf <= w_push_osd & w_osd_full & ~w_pop_osd;
  end

  assign osd_overflow = r_osd_ovf;
  assign key_osd      = r_key_osd;
`else
  assign w_osd_head   = '0;
  assign w_osd_empty  = 1'b1;
  assign osd_overflow = 1'b0;
  assign key_osd      = 1'b0;
`endif

  // On a tie the source not granted last wins; a lone non-empty queue always wins.
  assign w_grant_osd = ~w_osd_empty & (w_kbd_empty | ~r_last_osd);
  assign w_any       = ~w_kbd_empty | ~w_osd_empty;
  assign w_pop_kbd   = (r_state == ST_IDLE) & ~w_kbd_empty & ~w_grant_osd;
  assign w_pop_osd   = (r_state == ST_IDLE) & w_grant_osd;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_m0x     <= '0;
      r_m0y     <= '0;
      r_m0w     <= '0;
      r_m1x     <= '0;
      r_m1y     <= '0;
      r_m1w     <= '0;
      r_yseen   <= '0;
      r_kbd_ovf <= 1'b0;
    end else begin
      r_kbd_ovf <= w_push_kbd & w_kbd_full & ~w_pop_kbd;
      if (kms_strobe && kms_type == KMS_MOUSE_X) begin
        if (mouse_idx) r_m1x <= r_m1x + kms_data;
        else           r_m0x <= r_m0x + kms_data;
        r_yseen[mouse_idx] <= 1'b0;
      end else if (kms_strobe && kms_type == KMS_MOUSE_Y) begin
        // First Y-type strobe of a packet is Y, the second is the wheel.
        if (!r_yseen[mouse_idx]) begin
          if (mouse_idx) r_m1y <= r_m1y + kms_data;
          else           r_m0y <= r_m0y + kms_data;
          r_yseen[mouse_idx] <= 1'b1;
        end else begin
          if (mouse_idx) r_m1w <= r_m1w + kms_data;
          else           r_m0w <= r_m0w + kms_data;
          r_yseen[mouse_idx] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_key_valid <= 1'b0;
      r_key_data  <= '0;
      r_key_osd   <= 1'b0;
      r_last_osd  <= 1'b0;
      r_timer     <= '0;
      r_retry_cnt <= '0;
      r_retry_p   <= 1'b0;
      r_lost_p    <= 1'b0;
    end else begin
      r_retry_p <= 1'b0;
      r_lost_p  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_timer     <= '0;
          r_retry_cnt <= '0;
          if (w_any) begin
            r_key_data  <= w_grant_osd ? w_osd_head : w_kbd_head;
            r_key_osd   <= w_grant_osd;
            r_last_osd  <= w_grant_osd;
            r_key_valid <= 1'b1;
            r_state     <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (key_ack) begin
            r_key_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (r_timer == L_TMAX) begin
            if (r_retry_cnt < L_RMAX) begin
              r_retry_p   <= 1'b1;
              r_retry_cnt <= r_retry_cnt + 1'b1;
              r_timer     <= '0;
            end else begin
              r_lost_p    <= 1'b1;
              r_key_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mouse0_x     = r_m0x;
  assign mouse0_y     = r_m0y;
  assign mouse0_w     = r_m0w;
  assign mouse1_x     = r_m1x;
  assign mouse1_y     = r_m1y;
  assign mouse1_w     = r_m1w;
  assign key_valid    = r_key_valid;
  assign key_data     = r_key_data;
  assign key_retry    = r_retry_p;
  assign key_lost     = r_lost_p;
  assign kbd_overflow = r_kbd_ovf;

endmodule
